object_capture: RTL and testbench

- Receiving end of the pixel-plot interface (x, y, color, plot strobe) used by our drawing blocks.
- Snoops a plot stream and captures the pixels that fall inside a 16x16 object window into an internal 256-entry object buffer.
- The buffer uses the same {y[3:0], x[3:0]} address layout as object_mem, so a drawn object can be read back and compared.
- Sits beside the VGA adapter in bring-up and test tops; readback goes to HEX/LEDR logic or a bench.

---
 rtl/object_capture.sv | 109 ++++++++++
 tb/tb_object_capture.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/object_capture.sv
// Captures plotted pixels that land inside a 16x16 window into a 256-entry
// object buffer addressed {row[3:0], col[3:0]}, with a registered readback port.
module object_capture #(
   parameter int unsigned N       = 8,
   parameter int unsigned XOFFSET = 72,
   parameter int unsigned YOFFSET = 52,
   parameter int unsigned COLOR_W = 24
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               arm,
   input  logic [N-1:0]       vga_x,
   input  logic [N-2:0]       vga_y,
   input  logic [COLOR_W-1:0] vga_color,
   input  logic               plot,
   input  logic [7:0]         rd_addr,
   output logic [COLOR_W-1:0] rd_data,
   output logic               busy,
   output logic               done,
   output logic [8:0]         count,
   output logic               dup,
   output logic [7:0]         miss_count
);

   localparam int unsigned YW    = N - 1;
   localparam int unsigned DEPTH = 256;
   localparam logic [N-1:0]  X_LO = N'(XOFFSET);
   localparam logic [N-1:0]  X_HI = N'(XOFFSET + 15);
   localparam logic [YW-1:0] Y_LO = YW'(YOFFSET);
   localparam logic [YW-1:0] Y_HI = YW'(YOFFSET + 15);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

   state_t             state, state_nx;
   logic [DEPTH-1:0]   valid;
   logic [COLOR_W-1:0] mem [DEPTH];

   logic       hit_c;
   logic [7:0] wr_addr_c;
   logic       clr_c, wr_en_c, miss_inc_c;

   // Unsigned bounds on both sides, so columns left of the window never wrap in.
   assign hit_c     = (vga_x >= X_LO) && (vga_x <= X_HI) &&
                      (vga_y >= Y_LO) && (vga_y <= Y_HI);
   assign wr_addr_c = {4'(vga_y - Y_LO), 4'(vga_x - X_LO)};

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next state and datapath strobes; arm overrides any concurrent plot.
   always_comb begin
      state_nx   = state;
      clr_c      = 1'b0;
      wr_en_c    = 1'b0;
      miss_inc_c = 1'b0;
      if (arm) begin
         state_nx = S_CAPTURE;
         clr_c    = 1'b1;
      end else if (state == S_CAPTURE && plot) begin
         if (hit_c) begin
            wr_en_c = 1'b1;
            if (!valid[wr_addr_c] && count == 9'd255) state_nx = S_DONE;
         end else begin
            miss_inc_c = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         valid      <= '0;
         count      <= 9'd0;
         dup        <= 1'b0;
         miss_count <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_nx == S_CAPTURE);
         done <= (state_nx == S_DONE);
         if (clr_c) begin
            valid      <= '0;
            count      <= 9'd0;
            dup        <= 1'b0;
            miss_count <= 8'd0;
         end else begin
            if (wr_en_c) begin
               valid[wr_addr_c] <= 1'b1;
               if (valid[wr_addr_c]) dup   <= 1'b1;
               else                  count <= count + 9'd1;
            end
            if (miss_inc_c && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
         end
      end
   end

   // Buffer storage is not reset; the valid bits mask stale contents.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en_c) mem[wr_addr_c] <= vga_color;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)            rd_data <= '0;
      else if (valid[rd_addr]) rd_data <= mem[rd_addr];
      else                    rd_data <= '0;
   end

endmodule

// File: tb/tb_object_capture.sv
// Directed and randomized checks of object_capture against a pixel-set model.
module tb_object_capture;

   logic        CLOCK_50 = 1'b0;
   logic        resetn, arm, plot;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [23:0] vga_color;
   logic [7:0]  rd_addr;
   logic [23:0] rd_data;
   logic        busy, done, dup;
   logic [8:0]  count;
   logic [7:0]  miss_count;

   int errors = 0;
   int checks = 0;

   // Reference model: which window pixels hold which colour, plus counters.
   logic [23:0] m_mem [256];
   bit          m_valid [256];
   bit          m_capturing, m_finished, m_dup;
   int          m_count, m_miss;
   logic [23:0] m_rd;

   object_capture dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .arm(arm), .vga_x(vga_x), .vga_y(vga_y),
      .vga_color(vga_color), .plot(plot), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .count(count), .dup(dup), .miss_count(miss_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ":busy"},  32'(busy),       32'(m_capturing));
      chk({tag, ":done"},  32'(done),       32'(m_finished));
      chk({tag, ":count"}, 32'(count),      32'(m_count));
      chk({tag, ":dup"},   32'(dup),        32'(m_dup));
      chk({tag, ":miss"},  32'(miss_count), 32'(m_miss));
      chk({tag, ":rd"},    32'(rd_data),    32'(m_rd));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      m_capturing = 0; m_finished = 0; m_dup = 0;
      m_count = 0; m_miss = 0; m_rd = '0;
   endtask

   // One clock: drive at the falling edge, advance the model, check just after the rising edge.
   task automatic step(input bit a, input bit p, input int x, input int y,
                       input logic [23:0] c, input int rd, input string tag);
      int idx;
      @(negedge CLOCK_50);
      arm = a; plot = p; vga_x = 8'(x); vga_y = 7'(y); vga_color = c; rd_addr = 8'(rd);
      @(posedge CLOCK_50);
      #1;
      m_rd = m_valid[rd] ? m_mem[rd] : 24'h0;
      if (a) begin
         for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
         m_capturing = 1; m_finished = 0; m_dup = 0; m_count = 0; m_miss = 0;
      end else if (m_capturing && p) begin
         if (x >= 72 && x <= 87 && y >= 52 && y <= 67) begin
            idx = (y - 52) * 16 + (x - 72);
            if (m_valid[idx]) m_dup = 1;
            else m_count++;
            m_valid[idx] = 1'b1;
            m_mem[idx] = c;
            if (m_count == 256) begin m_capturing = 0; m_finished = 1; end
         end else if (m_miss < 255) begin
            m_miss++;
         end
      end
      chk_all(tag);
   endtask

   task automatic raster(input int n, input bit rnd_color);
      logic [23:0] c;
      for (int i = 0; i < n; i++) begin
         c = rnd_color ? 24'($urandom) : 24'h010101 * 24'(i);
         step(0, 1, 72 + i % 16, 52 + i / 16, c, $urandom_range(0, 255), "raster");
      end
   endtask

   task automatic rand_miss(output int x, output int y);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 127);
      if (x >= 72 && x <= 87 && y >= 52 && y <= 67) x = 0;
   endtask

   initial begin
      int mx, my;
      resetn = 1'b0; arm = 0; plot = 0; vga_x = '0; vga_y = '0; vga_color = '0; rd_addr = '0;
      model_reset();
      repeat (3) @(posedge CLOCK_50);
      #1 chk_all("in_reset");
      @(negedge CLOCK_50) resetn = 1'b1;

      // Reset readback
      step(0, 0, 0, 0, 0, 8'h00, "rst_rd00");
      step(0, 0, 0, 0, 0, 8'hFF, "rst_rdFF");

      // Full raster capture
      step(1, 0, 0, 0, 0, 0, "arm_full");
      raster(256, 0);
      chk("full_done", 32'(done), 32'd1);
      chk("full_count", 32'(count), 32'd256);
      step(0, 0, 0, 0, 0, 8'h35, "rd35_req");
      chk("rd35", 32'(rd_data), 32'h353535);

      // Plots after DONE are ignored
      step(0, 1, 72, 52, 24'hFFFFFF, 0, "done_plot");
      step(0, 0, 0, 0, 0, 0, "done_rd00");
      chk("done_rd00_val", 32'(rd_data), 32'h000000);

      // Window edge misses, then saturation
      step(1, 0, 0, 0, 0, 0, "arm_miss");
      step(0, 1, 71, 52, 24'h1, 0, "miss_x_lo");
      step(0, 1, 88, 52, 24'h2, 0, "miss_x_hi");
      step(0, 1, 72, 68, 24'h3, 0, "miss_y_hi");
      step(0, 1, 72, 51, 24'h4, 0, "miss_y_lo");
      chk("miss4", 32'(miss_count), 32'd4);
      chk("miss4_count", 32'(count), 32'd0);
      for (int i = 0; i < 300; i++) begin
         rand_miss(mx, my);
         step(0, 1, mx, my, 24'($urandom), $urandom_range(0, 255), "miss_sat");
      end
      chk("miss_sat", 32'(miss_count), 32'd255);

      // Duplicate write, last write wins
      step(1, 0, 0, 0, 0, 0, "arm_dup");
      step(0, 1, 72, 52, 24'hAAAAAA, 0, "dup_a");
      step(0, 1, 72, 52, 24'h555555, 0, "dup_b");
      step(0, 0, 0, 0, 0, 8'h00, "dup_rd");
      chk("dup_rd_val", 32'(rd_data), 32'h555555);
      chk("dup_flag", 32'(dup), 32'd1);

      // Asynchronous reset mid-capture
      step(1, 0, 0, 0, 0, 0, "arm_rst");
      raster(100, 1);
      #3 resetn = 1'b0;
      #1 model_reset();
      chk_all("async_rst");
      @(negedge CLOCK_50) resetn = 1'b1;
      for (int a = 0; a < 256; a++)
         step(0, 1, 72 + a % 16, 52 + a / 16, 24'hFFFFFF, a, "post_rst");

      // Re-arm from DONE with a plot in the arm cycle
      step(1, 0, 0, 0, 0, 0, "arm_redo");
      raster(256, 1);
      chk("redo_done", 32'(done), 32'd1);
      step(1, 1, 72, 52, 24'h123456, 0, "rearm");
      chk("rearm_busy", 32'(busy), 32'd1);
      chk("rearm_count", 32'(count), 32'd0);
      step(0, 0, 0, 0, 0, 8'h00, "rearm_rd");
      chk("rearm_rd_val", 32'(rd_data), 32'h000000);

      // Random plots around the window with random readback and occasional re-arm
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              $urandom_range(66, 93), $urandom_range(46, 73), 24'($urandom),
              $urandom_range(0, 255), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
